// File: rtl/count_up_if.sv
// count_up_if -- control and display bundle for count_up.
//   start, pause, clear, lap : control requests, level-sampled on clock_50
//   display_0, display_1     : active-low 7-segment units/tens, gfedcba order
//   running, time_up         : state flags (RUN / DONE)
// master modport drives the controls, slave modport is the counter.
interface count_up_if;
   logic       start;
   logic       pause;
   logic       clear;
   logic       lap;
   logic [6:0] display_0;
   logic [6:0] display_1;
   logic       running;
   logic       time_up;

   modport master (
      output start, pause, clear, lap,
      input  display_0, display_1, running, time_up
   );

   modport slave (
      input  start, pause, clear, lap,
      output display_0, display_1, running, time_up
   );
endinterface

// File: rtl/count_up.sv
// count_up -- seconds up-counter with BCD 7-segment display and DONE limit.
// Ports:
//   clock_50 : system clock, all registers update on its rising edge
//   reset    : synchronous active-high reset
//   bus      : count_up_if.slave (start/pause/clear/lap in, displays/flags out)
// Parameters:
//   TICKS_PER_SEC : clock cycles per one-second tick (2..2^26)
//   LIMIT         : terminal seconds value (1..99)
// Build option:
//   COUNT_UP_LAP_EN : when defined, lap toggles a display freeze showing a
//                     captured lap value; when undefined, lap is unused.
module count_up #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned LIMIT         = 30
) (
   input logic       clock_50,
   input logic       reset,
   count_up_if.slave bus
);

   localparam int unsigned   PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [6:0]    LIMIT_VAL  = 7'(LIMIT);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] presc;
   logic [3:0]    units;
   logic [3:0]    tens;
   logic          tick;
   logic          reach_limit;
   logic [3:0]    shown_units;
   logic [3:0]    shown_tens;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // One-second strobe and "this tick lands on LIMIT" look-ahead.
   always_comb begin
      tick        = (state == RUN) && (presc == PRESC_LAST);
      reach_limit = (({3'b000, tens} * 7'd10) + {3'b000, units} + 7'd1) == LIMIT_VAL;
   end

   // State register
   always_ff @(posedge clock_50) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: clear dominates, simultaneous start+pause is a no-op,
   // and reaching LIMIT wins over a concurrent pause request.
   always_comb begin
      state_next = state;
      if (bus.clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, PAUSED: if (bus.start && !bus.pause) state_next = RUN;
            RUN: begin
               if (tick && reach_limit)           state_next = DONE;
               else if (bus.pause && !bus.start)  state_next = PAUSED;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Prescaler and BCD count; both only move while RUN, so PAUSED keeps the
   // partial second and DONE holds the count at LIMIT.
   always_ff @(posedge clock_50) begin
      if (reset || bus.clear) begin
         presc <= '0;
         units <= '0;
         tens  <= '0;
      end else if (state == RUN) begin
         if (tick) begin
            presc <= '0;
            if (units == 4'd9) begin
               units <= '0;
               tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
               units <= units + 4'd1;
            end
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

`ifdef COUNT_UP_LAP_EN
   logic [3:0] lap_units;
   logic [3:0] lap_tens;
   logic       freeze;

   // lap toggles: capture-and-freeze only from RUN, release from any state.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         lap_units <= '0;
         lap_tens  <= '0;
         freeze    <= 1'b0;
      end else if (bus.clear) begin
         freeze <= 1'b0;
      end else if (bus.lap) begin
         if (freeze) begin
            freeze <= 1'b0;
         end else if (state == RUN) begin
            lap_units <= units;
            lap_tens  <= tens;
            freeze    <= 1'b1;
         end
      end
   end

   always_comb begin
      shown_units = freeze ? lap_units : units;
      shown_tens  = freeze ? lap_tens  : tens;
   end
`else
   logic lap_unused;

   always_comb begin
      lap_unused  = bus.lap;
      shown_units = units;
      shown_tens  = tens;
   end
`endif

   // Output decode
   always_comb begin
      bus.running   = (state == RUN);
      bus.time_up   = (state == DONE);
      bus.display_0 = seg7(shown_units);
      bus.display_1 = seg7(shown_tens);
   end

endmodule

// File: tb/tb_count_up.sv
// tb_count_up -- randomized self-checking bench for count_up
// (TICKS_PER_SEC=4, LIMIT=12). A seconds-level model predicts the displays
// and flags every cycle; define COUNT_UP_LAP_EN to also exercise the lap path.
module tb_count_up;
   localparam int unsigned T   = 4;
   localparam int unsigned LIM = 12;

   logic clock_50 = 1'b0;
   logic reset;

   count_up_if bus();

   count_up #(.TICKS_PER_SEC(T), .LIMIT(LIM)) dut (
      .clock_50 (clock_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 clock_50 = ~clock_50;

   int total = 0;
   int bad   = 0;

   typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
   mstate_t m_st;
   int      m_presc;
   int      m_secs;
   int      m_lap;
   bit      m_freeze;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   // Seconds-level reference: one call per rising edge.
   task automatic model_update();
      bit tk;
      if (reset) begin
         m_st = M_IDLE; m_presc = 0; m_secs = 0; m_lap = 0; m_freeze = 0;
      end else if (bus.clear) begin
         m_st = M_IDLE; m_presc = 0; m_secs = 0; m_freeze = 0;
      end else begin
         tk = (m_st == M_RUN) && (m_presc == T - 1);
`ifdef COUNT_UP_LAP_EN
         if (bus.lap) begin
            if (m_freeze) m_freeze = 0;
            else if (m_st == M_RUN) begin m_lap = m_secs; m_freeze = 1; end
         end
`endif
         if (m_st == M_RUN) m_presc = (m_presc + 1) % T;
         case (m_st)
            M_IDLE, M_PAUSED: if (bus.start && !bus.pause) m_st = M_RUN;
            M_RUN: begin
               if (tk) m_secs++;
               if (tk && m_secs == LIM)              m_st = M_DONE;
               else if (bus.pause && !bus.start)     m_st = M_PAUSED;
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [15:0] exp_out();
      int shown;
      shown = m_freeze ? m_lap : m_secs;
      return {seg_tab[shown / 10], seg_tab[shown % 10], m_st == M_RUN, m_st == M_DONE};
   endfunction

   task automatic step();
      @(posedge clock_50);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.start = 0; bus.pause = 0; bus.clear = 0; bus.lap = 0; reset = 0;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      idle_inputs();
      reset = 1; bus.start = 1; bus.lap = 1;
      step();
      got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
      total++;
      if (got !== {7'b1000000, 7'b1000000, 2'b00}) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", got, {7'b1000000, 7'b1000000, 2'b00});
      end
      idle_inputs();
      step();
   endtask

   task automatic test_start_count();
      logic [15:0] got;
      bus.start = 1;
      step();
      bus.start = 0;
      total++;
      if (bus.running !== 1'b1) begin
         bad++; $display("FAIL start_running got=%b exp=1", bus.running);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL start_count cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      total++;
      if (bus.display_0 !== 7'b1111001) begin
         bad++; $display("FAIL first_second d0 got=%b exp=1111001", bus.display_0);
      end
   endtask

   task automatic test_rollover();
      logic [15:0] got;
      for (int i = 0; i < 200 && m_secs < 10; i++) begin
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL rollover_run cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      total++;
      if (bus.display_1 !== 7'b1111001 || bus.display_0 !== 7'b1000000) begin
         bad++; $display("FAIL rollover_10 got=%b_%b exp=1111001_1000000", bus.display_1, bus.display_0);
      end
   endtask

   task automatic test_pause_resume();
      logic [15:0] got;
      int s;
      for (int i = 0; i < 20 && m_presc != 1; i++) step();
      bus.pause = 1;
      step();
      bus.pause = 0;
      for (int i = 0; i < 20; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.pause = bus.start;
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL pause_hold cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      idle_inputs();
      s = m_secs;
      bus.start = 1;
      step();
      bus.start = 0;
      step();
      total++;
      if (bus.display_0 !== seg_tab[s % 10] || bus.running !== 1'b1) begin
         bad++; $display("FAIL resume_early got=%b r=%b exp=%b r=1", bus.display_0, bus.running, seg_tab[s % 10]);
      end
      step();
      total++;
      if (bus.display_0 !== seg_tab[(s + 1) % 10]) begin
         bad++; $display("FAIL resume_tick got=%b exp=%b", bus.display_0, seg_tab[(s + 1) % 10]);
      end
   endtask

   task automatic test_limit();
      logic [15:0] got;
      for (int i = 0; i < 200 && m_st != M_DONE; i++) begin
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL limit_run cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
      total++;
      if (got !== {7'b1111001, 7'b0100100, 2'b01}) begin
         bad++; $display("FAIL limit_done got=%h exp=%h", got, {7'b1111001, 7'b0100100, 2'b01});
      end
      for (int i = 0; i < 100; i++) begin
         bus.start = $urandom_range(0, 1);
         bus.pause = ($urandom_range(0, 3) == 0);
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL done_hold cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      idle_inputs();
      bus.clear = 1;
      step();
      bus.clear = 0;
      got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
      total++;
      if (got !== {7'b1000000, 7'b1000000, 2'b00}) begin
         bad++; $display("FAIL clear_done got=%h exp=%h", got, {7'b1000000, 7'b1000000, 2'b00});
      end
   endtask

   task automatic test_both_and_reset();
      logic [15:0] got;
      bus.start = 1;
      step();
      for (int i = 0; i < 200 && m_secs < 7; i++) begin
         bus.start = ($urandom_range(0, 1) == 1);
         bus.pause = bus.start;
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL both_req cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      reset = 1; bus.start = 1; bus.pause = 0; bus.clear = 1; bus.lap = 1;
      step();
      idle_inputs();
      got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
      total++;
      if (got !== {7'b1000000, 7'b1000000, 2'b00}) begin
         bad++; $display("FAIL reset_mid got=%h exp=%h", got, {7'b1000000, 7'b1000000, 2'b00});
      end
   endtask

`ifdef COUNT_UP_LAP_EN
   task automatic test_lap();
      logic [15:0] got;
      bus.start = 1;
      step();
      bus.start = 0;
      for (int i = 0; i < 100 && m_secs < 3; i++) step();
      bus.lap = 1;
      step();
      bus.lap = 0;
      for (int i = 0; i < 100 && m_secs < 6; i++) begin
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL lap_frozen cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      total++;
      if (bus.display_0 !== seg_tab[3]) begin
         bad++; $display("FAIL lap_hold03 got=%b exp=%b", bus.display_0, seg_tab[3]);
      end
      bus.lap = 1;
      step();
      bus.lap = 0;
      total++;
      if (bus.display_0 !== seg_tab[6] || bus.display_1 !== seg_tab[0]) begin
         bad++; $display("FAIL lap_release got=%b_%b exp=%b_%b", bus.display_1, bus.display_0, seg_tab[0], seg_tab[6]);
      end
   endtask
`endif

   task automatic test_random();
      logic [15:0] got;
      for (int i = 0; i < 600; i++) begin
         bus.start = ($urandom_range(0, 3) == 0);
         bus.pause = ($urandom_range(0, 5) == 0);
         bus.clear = ($urandom_range(0, 59) == 0);
         bus.lap   = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 119) == 0);
         step();
         got = {bus.display_1, bus.display_0, bus.running, bus.time_up};
         total++;
         if (got !== exp_out()) begin
            bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_out());
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_start_count();
      test_rollover();
      test_pause_resume();
      test_limit();
      test_both_and_reset();
`ifdef COUNT_UP_LAP_EN
      test_lap();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
